usb_sie_phase_ctrl: RTL
=======================

Name: usb_sie_phase_ctrl

Overview:
Sequences the shared SIE datapath (CRC engine, bit-stuffing wrapper, DPPL-derived clock) between receive and transmit phases. It drives the SIE's isSendingPhase select and gates the protocol engine's send request behind a minimum inter-packet gap. After a transmit that expects a handshake, it enforces the bus-turnaround response timeout. It sits between the protocol engine and usb_sie, in the clk12_i domain.

Parameters:
MIN_GAP, 2, clk12_i cycles between isSendingPhase_o rising and the txReqSendPacket_o pulse (must be >=1)
RESP_TIMEOUT, 18, cycles after TX completion to wait for the first received byte
TX_WATCHDOG, 10000, maximum cycles from the txReqSendPacket_o pulse to txDoneSending_i
CNT_W, 14, width of the shared down-counter; must hold max(MIN_GAP, RESP_TIMEOUT, TX_WATCHDOG)

Ports:
clk12_i  in  1  full-speed logic clock
rstn_i  in  1  asynchronous active-low reset
usbResetDetected_i  in  1  USB bus reset seen (from SIE)
rxDataValid_i  in  1  SIE rx byte valid
rxAcceptNewData_i  in  1  consumer accepts the rx byte (observed only)
rxIsLastByte_i  in  1  current rx byte is the last one
keepPacket_i  in  1  rx packet error-free, sampled with the last byte
txDoneSending_i  in  1  SIE single-cycle end-of-transmit pulse
txReq_i  in  1  protocol engine requests to send; level, held until txGrant_o
txExpectResp_i  in  1  the packet expects a handshake; sampled when txGrant_o is high
isSendingPhase_o  out  1  datapath select to SIE (1 = TX)
txReqSendPacket_o  out  1  single-cycle send request to SIE
txGrant_o  out  1  single-cycle grant to the requester, coincident with txReqSendPacket_o
rxPacketDone_o  out  1  single-cycle pulse: rx packet completed
rxPacketOk_o  out  1  keepPacket_i captured at completion; valid while rxPacketDone_o is high
respTimeout_o  out  1  single-cycle pulse: no response within RESP_TIMEOUT
txWatchdog_o  out  1  single-cycle pulse: TX did not finish within TX_WATCHDOG
state_o  out  3  current state encoding, for debug

Behaviour:
- Reset (rstn_i low, asynchronous): state=RX_IDLE; all outputs 0; counter 0; latched expect-response flag 0.
- All outputs are registered.
- Handshake on the last rx byte: lastHs = rxDataValid_i && rxAcceptNewData_i && rxIsLastByte_i.
- States (state_o encoding): RX_IDLE=0, RX_BUSY=1, TX_GAP=2, TX_ACTIVE=3, AWAIT_RESP=4.
- RX_IDLE:
  - rxDataValid_i -> RX_BUSY.
  - Else txReq_i -> TX_GAP; isSendingPhase_o<=1; counter<=MIN_GAP-1.
  - If rxDataValid_i and txReq_i are both high, rx wins and the tx request stays pending.
- RX_BUSY:
  - lastHs -> rxPacketDone_o=1 and rxPacketOk_o=keepPacket_i on the next cycle; -> RX_IDLE.
  - txReq_i is ignored (deferred) while in RX_BUSY.
- TX_GAP:
  - Counter decrements each cycle.
  - At counter==0: txReqSendPacket_o=1 and txGrant_o=1 for one cycle; latch txExpectResp_i; counter<=TX_WATCHDOG-1; -> TX_ACTIVE.
  - Latency from txReq_i accepted in RX_IDLE to the pulse is MIN_GAP+1 cycles.
- TX_ACTIVE:
  - isSendingPhase_o stays 1.
  - txDoneSending_i -> isSendingPhase_o<=0. If the expect flag is set -> AWAIT_RESP with counter<=RESP_TIMEOUT-1; else -> RX_IDLE.
  - Counter==0 without done: txWatchdog_o pulse; isSendingPhase_o<=0; -> RX_IDLE.
  - If done and counter==0 occur in the same cycle, done wins and there is no watchdog pulse.
- AWAIT_RESP:
  - isSendingPhase_o=0.
  - rxDataValid_i -> RX_BUSY. A single-byte packet with lastHs in the same cycle completes directly: pulse rxPacketDone_o, -> RX_IDLE.
  - Counter==0 without rxDataValid_i: respTimeout_o pulse; -> RX_IDLE.
  - If rxDataValid_i and timeout coincide, rx wins.
  - txReq_i is ignored in this state.
- usbResetDetected_i (highest priority, any state) -> RX_IDLE next cycle:
  - isSendingPhase_o<=0, counter cleared, expect flag cleared.
  - No pulses generated, including any pending done, timeout or watchdog.
  - While it is held high, the block stays in RX_IDLE and accepts nothing.
- txDoneSending_i outside TX_ACTIVE is ignored.
- Counter: unsigned CNT_W bits; decrements only in TX_GAP, TX_ACTIVE and AWAIT_RESP; never wraps, because every state exits at 0.
- Reset asserted mid-transfer: outputs drop to 0 immediately (asynchronous) and no pulse is completed.

Test Plan:
- MIN_GAP=2, txReq_i high in RX_IDLE at cycle 0 -> isSendingPhase_o=1 at cycle 1; txReqSendPacket_o/txGrant_o pulse at cycle 3; txDoneSending_i at cycle 40 with txExpectResp_i=0 -> isSendingPhase_o=0 at cycle 41; state_o=0.
- TX with txExpectResp_i=1, done at cycle T, no rx -> respTimeout_o pulse at cycle T+1+18; state_o=0. Repeat with rxDataValid_i at T+10 -> state_o=1, no timeout.
- rxDataValid_i and txReq_i rise together in RX_IDLE, 3-byte packet, last byte with keepPacket_i=0 -> rxPacketDone_o=1 with rxPacketOk_o=0. Tx is granted MIN_GAP+1 cycles after returning to RX_IDLE.
- TX_WATCHDOG=50, no txDoneSending_i -> txWatchdog_o pulses exactly 50 cycles after txReqSendPacket_o; isSendingPhase_o=0 on the same edge.
- usbResetDetected_i asserted in TX_ACTIVE and in AWAIT_RESP -> state_o=0 and isSendingPhase_o=0 next cycle; respTimeout_o and txWatchdog_o never pulse.
- rstn_i pulled low mid-TX_GAP without a clock edge -> all outputs 0 immediately; after release, a fresh txReq_i yields normal MIN_GAP+1 latency.

Source files
------------

// File: rtl/usb_sie_phase_ctrl.sv
// usb_sie_phase_ctrl
// Arbitrates the shared SIE datapath (CRC, bit stuffing, DPLL clock) between
// the receive and transmit phases, in the clk12_i domain.
//  - A send request from the protocol engine is held back until isSendingPhase_o
//    has been high for MIN_GAP cycles, then turned into one txReqSendPacket_o /
//    txGrant_o pulse.
//  - A transmit that expects a handshake opens a RESP_TIMEOUT response window.
//  - A transmit that never reports done is abandoned after TX_WATCHDOG cycles.
//
// Ports:
//   clk12_i             full-speed logic clock
//   rstn_i              asynchronous active-low reset
//   usbResetDetected_i  USB bus reset, forces the idle receive phase
//   rxDataValid_i       rx byte valid from the SIE
//   rxAcceptNewData_i   consumer accepts the rx byte
//   rxIsLastByte_i      current rx byte is the last one of the packet
//   keepPacket_i        rx packet error-free, meaningful with the last byte
//   txDoneSending_i     end-of-transmit pulse from the SIE
//   txReq_i             send request level from the protocol engine
//   txExpectResp_i      packet being granted expects a handshake
//   isSendingPhase_o    datapath select towards the SIE (1 = transmit)
//   txReqSendPacket_o   single-cycle send request towards the SIE
//   txGrant_o           single-cycle grant back to the requester
//   rxPacketDone_o      single-cycle rx packet completion pulse
//   rxPacketOk_o        packet status, valid with rxPacketDone_o
//   respTimeout_o       single-cycle pulse: no response arrived in time
//   txWatchdog_o        single-cycle pulse: transmit never finished
//   state_o             current phase, for debug
module usb_sie_phase_ctrl #(
   parameter int MIN_GAP      = 2,
   parameter int RESP_TIMEOUT = 18,
   parameter int TX_WATCHDOG  = 10000,
   parameter int CNT_W        = 14
) (
   input  logic       clk12_i,
   input  logic       rstn_i,
   input  logic       usbResetDetected_i,
   input  logic       rxDataValid_i,
   input  logic       rxAcceptNewData_i,
   input  logic       rxIsLastByte_i,
   input  logic       keepPacket_i,
   input  logic       txDoneSending_i,
   input  logic       txReq_i,
   input  logic       txExpectResp_i,
   output logic       isSendingPhase_o,
   output logic       txReqSendPacket_o,
   output logic       txGrant_o,
   output logic       rxPacketDone_o,
   output logic       rxPacketOk_o,
   output logic       respTimeout_o,
   output logic       txWatchdog_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      RX_IDLE    = 3'd0,
      RX_BUSY    = 3'd1,
      TX_GAP     = 3'd2,
      TX_ACTIVE  = 3'd3,
      AWAIT_RESP = 3'd4
   } phaseState_t;

   // Load values are one less than the cycle counts because each timed state
   // acts on the cycle where the counter reads zero.
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(MIN_GAP - 1);
   localparam logic [CNT_W-1:0] RESP_LOAD = CNT_W'(RESP_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] WD_LOAD   = CNT_W'(TX_WATCHDOG - 1);

   phaseState_t      state, stateNext;
   logic [CNT_W-1:0] count, countNext;
   logic             expectResp, expectRespNext;
   logic             sendingNext;
   logic             sendReqNext;
   logic             grantNext;
   logic             rxDoneNext;
   logic             rxOkNext;
   logic             respTimeoutNext;
   logic             watchdogNext;
   logic             lastHs;
   logic             countZero;

   assign lastHs    = rxDataValid_i && rxAcceptNewData_i && rxIsLastByte_i;
   assign countZero = (count == '0);
   assign state_o   = state;

   // Phase register and every output flop live here, so all outputs are
   // registered and drop to zero the moment rstn_i falls.
   always_ff @(posedge clk12_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state             <= RX_IDLE;
         count             <= '0;
         expectResp        <= 1'b0;
         isSendingPhase_o  <= 1'b0;
         txReqSendPacket_o <= 1'b0;
         txGrant_o         <= 1'b0;
         rxPacketDone_o    <= 1'b0;
         rxPacketOk_o      <= 1'b0;
         respTimeout_o     <= 1'b0;
         txWatchdog_o      <= 1'b0;
      end else begin
         state             <= stateNext;
         count             <= countNext;
         expectResp        <= expectRespNext;
         isSendingPhase_o  <= sendingNext;
         txReqSendPacket_o <= sendReqNext;
         txGrant_o         <= grantNext;
         rxPacketDone_o    <= rxDoneNext;
         rxPacketOk_o      <= rxOkNext;
         respTimeout_o     <= respTimeoutNext;
         txWatchdog_o      <= watchdogNext;
      end
   end

   // Next-phase and next-output decisions. Pulses default to zero so each one
   // lasts a single cycle. A bus reset overrides everything, including pulses
   // that would otherwise fire on the same edge. Returning to a receive phase
   // parks the counter at zero; only the timed phases load and decrement it.
   always_comb begin
      stateNext       = state;
      countNext       = count;
      expectRespNext  = expectResp;
      sendingNext     = isSendingPhase_o;
      sendReqNext     = 1'b0;
      grantNext       = 1'b0;
      rxDoneNext      = 1'b0;
      rxOkNext        = 1'b0;
      respTimeoutNext = 1'b0;
      watchdogNext    = 1'b0;

      if (usbResetDetected_i) begin
         stateNext      = RX_IDLE;
         countNext      = '0;
         expectRespNext = 1'b0;
         sendingNext    = 1'b0;
      end else begin
         case (state)
            RX_IDLE: begin
               if (rxDataValid_i) begin
                  stateNext = RX_BUSY;
               end else if (txReq_i) begin
                  stateNext   = TX_GAP;
                  sendingNext = 1'b1;
                  countNext   = GAP_LOAD;
               end
            end
            RX_BUSY: begin
               if (lastHs) begin
                  stateNext  = RX_IDLE;
                  rxDoneNext = 1'b1;
                  rxOkNext   = keepPacket_i;
               end
            end
            TX_GAP: begin
               if (countZero) begin
                  stateNext      = TX_ACTIVE;
                  sendReqNext    = 1'b1;
                  grantNext      = 1'b1;
                  expectRespNext = txExpectResp_i;
                  countNext      = WD_LOAD;
               end else begin
                  countNext = count - CNT_W'(1);
               end
            end
            TX_ACTIVE: begin
               if (txDoneSending_i) begin
                  sendingNext = 1'b0;
                  if (expectResp) begin
                     stateNext = AWAIT_RESP;
                     countNext = RESP_LOAD;
                  end else begin
                     stateNext = RX_IDLE;
                     countNext = '0;
                  end
               end else if (countZero) begin
                  stateNext    = RX_IDLE;
                  sendingNext  = 1'b0;
                  watchdogNext = 1'b1;
               end else begin
                  countNext = count - CNT_W'(1);
               end
            end
            AWAIT_RESP: begin
               if (rxDataValid_i) begin
                  countNext = '0;
                  if (lastHs) begin
                     stateNext  = RX_IDLE;
                     rxDoneNext = 1'b1;
                     rxOkNext   = keepPacket_i;
                  end else begin
                     stateNext = RX_BUSY;
                  end
               end else if (countZero) begin
                  stateNext       = RX_IDLE;
                  respTimeoutNext = 1'b1;
               end else begin
                  countNext = count - CNT_W'(1);
               end
            end
            default: begin
               stateNext   = RX_IDLE;
               countNext   = '0;
               sendingNext = 1'b0;
            end
         endcase
      end
   end

endmodule
